// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and an internal carry flag.
// Optional macro ALU_PARITY_EN adds a registered parity output of the result.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CTL_W-1:0] ctl,
  input  logic             cf_wr,
  input  logic             cf_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err,
  output logic             cflag
`ifdef ALU_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] ALL_ONE = {1'b0, {WIDTH{1'b1}}};

  // Handshake: a beat transfers on a side when valid && ready at the rising edge.
  // S2 advances whenever its output register is empty or being consumed;
  // in_ready depends only on registered state and out_ready, never on in_valid.
  logic             s2_adv;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [CTL_W-1:0] s1_ctl_q, s1_ctl_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             cflag_q, cflag_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] bp;
  logic             co;
  logic             legal;
  logic             arith;
  logic             ovf_c;
  logic [WIDTH:0]   cin_ext;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign cin_ext  = {{WIDTH{1'b0}}, cflag_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ctl_d   = s1_ctl_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_ctl_d = ctl;
      end
    end
  end

  always_comb begin
    sum   = '0;
    r     = '0;
    co    = 1'b0;
    legal = 1'b1;
    arith = 1'b0;
    bp    = s1_b_q;
    case (s1_ctl_q)
      4'd0: r = s1_a_q;
      4'd1: begin sum = {1'b0, s1_b_q} + ONE; r = sum[WIDTH-1:0]; co = sum[WIDTH]; end
      4'd2: begin sum = {1'b0, s1_b_q} + ALL_ONE; r = sum[WIDTH-1:0]; co = sum[WIDTH]; end
      4'd3: begin
        arith = 1'b1;
        sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        r     = sum[WIDTH-1:0];
        co    = sum[WIDTH];
      end
      4'd4: begin
        arith = 1'b1;
        sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q} + cin_ext;
        r     = sum[WIDTH-1:0];
        co    = sum[WIDTH];
      end
      4'd5: begin
        arith = 1'b1;
        bp    = ~s1_b_q;
        sum   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + ONE;
        r     = sum[WIDTH-1:0];
        co    = sum[WIDTH];
      end
      4'd6: begin
        arith = 1'b1;
        bp    = ~s1_b_q;
        sum   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + cin_ext;
        r     = sum[WIDTH-1:0];
        co    = sum[WIDTH];
      end
      4'd7:  r = s1_a_q & s1_b_q;
      4'd8:  r = s1_a_q | s1_b_q;
      4'd9:  r = s1_a_q ^ s1_b_q;
      4'd10: begin r = {s1_b_q[WIDTH-2:0], 1'b1};    co = s1_b_q[WIDTH-1]; end
      4'd11: begin r = {1'b0, s1_b_q[WIDTH-1:1]};    co = s1_b_q[0];       end
      4'd12: begin r = {s1_b_q[WIDTH-2:0], cflag_q}; co = s1_b_q[WIDTH-1]; end
      4'd13: begin r = {cflag_q, s1_b_q[WIDTH-1:1]}; co = s1_b_q[0];       end
      default: legal = 1'b0;
    endcase
    // Signed overflow: operands agree in sign but the result does not.
    ovf_c = arith && (s1_a_q[WIDTH-1] == bp[WIDTH-1]) && (r[WIDTH-1] != s1_a_q[WIDTH-1]);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    cflag_d     = cflag_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = legal ? r : '0;
        carry_d  = legal && co;
        zero_d   = legal && (r == '0);
        neg_d    = legal && r[WIDTH-1];
        ovf_d    = legal && ovf_c;
        err_d    = !legal;
        if (legal) cflag_d = co;
      end
    end
    if (cf_wr) cflag_d = cf_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctl_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cflag_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_ctl_q    <= s1_ctl_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cflag_q     <= cflag_d;
    end
  end

`ifdef ALU_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (s2_adv && s1_valid_q) parity_d = legal ? ^r : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign parity = parity_q;
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign cflag     = cflag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): carry chain, flags, backpressure, illegal ops, reset.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ctl;
  logic         cf_wr;
  logic         cf_wdata;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         err;
  logic         cflag;
`ifdef ALU_PARITY_EN
  logic         parity;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  alu_pipe #(.WIDTH(W), .CTL_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctl(ctl), .cf_wr(cf_wr), .cf_wdata(cf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err), .cflag(cflag)
`ifdef ALU_PARITY_EN
    , .parity(parity)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    ctl      = c;
    a        = av;
    b        = bv;
  endtask

  // Issue one op at a negedge, wait for it to reach the output, leave sampling at a negedge.
  task automatic send_one(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    drive(c, av, bv);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctl = '0;
    cf_wr = 1'b0; cf_wdata = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cflag", cflag, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    // back-to-back add then add-with-carry
    @(negedge clk);
    drive(4'd3, 8'hF0, 8'h20);
    @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    drive(4'd4, 8'h01, 8'h01);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 8'h10);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 0);
    chk("add_ovf", ovf, 0);
    chk("add_cflag", cflag, 1);
    @(posedge clk);
    @(negedge clk);
    chk("adc_valid", out_valid, 1);
    chk("adc_result", result, 8'h03);
    chk("adc_carry", carry, 0);
    chk("adc_cflag", cflag, 0);
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", out_valid, 0);

    // subtract with overflow
    send_one(4'd5, 8'h80, 8'h01);
    chk("sub_result", result, 8'h7F);
    chk("sub_carry", carry, 1);
    chk("sub_ovf", ovf, 1);
    chk("sub_neg", neg, 0);
    chk("sub_cflag", cflag, 1);

    // force cflag to 0, then subtract-with-borrow 0-0
    cf_wr = 1'b1; cf_wdata = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cf_wr = 1'b0;
    chk("cfwr_clear", cflag, 0);
    send_one(4'd6, 8'h00, 8'h00);
    chk("sbc_result", result, 8'hFF);
    chk("sbc_carry", carry, 0);
    chk("sbc_neg", neg, 1);
    chk("sbc_ovf", ovf, 0);

    // shifts, inc/dec wrap
    cf_wr = 1'b1; cf_wdata = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cf_wr = 1'b0;
    send_one(4'd12, 8'h00, 8'h81);
    chk("rlc_result", result, 8'h03);
    chk("rlc_carry", carry, 1);
    send_one(4'd13, 8'h00, 8'h02);
    chk("rrc_result", result, 8'h81);
    chk("rrc_carry", carry, 0);
    send_one(4'd2, 8'h00, 8'h00);
    chk("dec_wrap", result, 8'hFF);
    chk("dec_carry", carry, 0);
    send_one(4'd1, 8'h00, 8'hFF);
    chk("inc_wrap", result, 8'h00);
    chk("inc_zero", zero, 1);
    chk("inc_carry", carry, 1);
    send_one(4'd10, 8'h00, 8'h40);
    chk("shl1_result", result, 8'h81);
    chk("shl1_carry", carry, 0);

    // illegal op with simultaneous cf_wr (cflag currently 0 after shl1)
    @(negedge clk);
    drive(4'hE, 8'h55, 8'hAA);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cf_wr = 1'b1; cf_wdata = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cf_wr = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_result", result, 8'h00);
    chk("ill_carry", carry, 0);
    chk("ill_cfwr_wins", cflag, 1);
    send_one(4'hF, 8'hFF, 8'hFF);
    chk("ill2_err", err, 1);
    chk("ill2_zero", zero, 0);
    chk("ill2_valid", out_valid, 1);
    chk("ill2_cflag_kept", cflag, 1);

    // backpressure: three ops against a stalled consumer
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd3, 8'h01, 8'h01); exp_q.push_back(8'h02);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_1", in_ready, 1);
    drive(4'd9, 8'hF0, 8'h3C); exp_q.push_back(8'hCC);
    @(posedge clk);
    @(negedge clk);
    drive(4'd8, 8'h0F, 8'h30); exp_q.push_back(8'h3F);
    chk("bp_ready_drop", in_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_0", result, 8'h02);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_still_blocked", in_ready, 0);
      chk("bp_held_stable", result, 8'h02);
    end
    out_ready = 1'b1;
    // scoreboard drain; the third op is accepted on the first edge below
    for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++) begin
      if (out_valid) begin
        chk("bp_order", result, exp_q.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      if (cyc == 0) in_valid = 1'b0;
    end
    chk("bp_none_lost", exp_q.size(), 0);

    // reset with two ops in flight
    @(negedge clk);
    drive(4'd3, 8'hFF, 8'h01);
    @(posedge clk);
    @(negedge clk);
    drive(4'd7, 8'hFF, 8'h0F);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_cflag", cflag, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cflag", cflag, 0);
    chk("arst_carry", carry, 0);
    chk("arst_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the 4-bit single-register ALU. It has a WIDTH-bit datapath, the same 14-op control encoding, and an internal carry-flag register, so carry-in no longer comes from outside. Full valid/ready handshaking on both sides, with backpressure. Adds overflow, negative and illegal-op flags, and sits between the operand-fetch stage and the register-file writeback.

Parameters:
WIDTH, 8, datapath width in bits (>=2)
CTL_W, 4, control field width (fixed encoding below; must be 4)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand/op valid
in_ready  out  1  block can accept an op this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ctl  in  CTL_W  operation select
cf_wr  in  1  direct write of carry-flag register
cf_wdata  in  1  value for cf_wr
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  ALU result
carry  out  1  carry out of this op
zero  out  1  result == 0
neg  out  1  result[WIDTH-1]
ovf  out  1  signed overflow (arith ops only)
err  out  1  illegal ctl for this result
cflag  out  1  current carry-flag register

Behaviour:
- Reset (async, active-high): s1_valid, out_valid, result, carry, zero, neg, ovf, err and cflag all go to 0. Any op in flight is discarded. On release, the first accept occurs no earlier than the next clk edge.
- Two stages. S1 captures a, b, ctl on in_valid && in_ready. S2 computes from S1 and registers all outputs.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput: 1 op/cycle.
- Stall rule: s2_adv = !out_valid || out_ready; in_ready = !s1_valid || s2_adv. No combinational path from in_valid to in_ready.
- Held outputs stay stable while out_valid && !out_ready.
- C means cflag, read when the op moves S1->S2. Ops update cflag serially in S2, so no forwarding is needed.
- Ops (r = result, co = carry), computed in WIDTH+1 bits:
  - 0: r=A, co=0
  - 1: B+1
  - 2: B-1, computed as B+all-ones; co = carry-out
  - 3: A+B
  - 4: A+B+C
  - 5: A+~B+1
  - 6: A+~B+C
  - 7: A&B, co=0
  - 8: A|B, co=0
  - 9: A^B, co=0
  - 10: r={B[W-2:0],1}, co=B[W-1]
  - 11: r={0,B[W-1:1]}, co=B[0]
  - 12: r={B[W-2:0],C}, co=B[W-1]
  - 13: r={C,B[W-1:1]}, co=B[0]
  - 14, 15: illegal
- cflag update: on each legal op entering S2, cflag <= co. Illegal ops leave cflag unchanged.
- cf_wr writes cflag in the same edge. If cf_wr and an op update coincide, cf_wr wins.
- Flags:
  - zero = (r==0) over WIDTH bits.
  - neg = r[W-1].
  - ovf only for ops 3-6: for add, a[msb]==b'[msb] && r[msb]!=a[msb], where b' = B or ~B. ovf=0 for all other ops.
- Illegal ctl: result=0, carry=0, zero=0, neg=0, ovf=0, err=1. out_valid is still produced.
- Wrap-around: arithmetic is mod 2^WIDTH; the bit above goes to co.

Optional Feature:
ALU_PARITY_EN:
- Defined: adds output port parity (1 bit) = XOR of all result bits. It is registered with result, is 0 on reset and 0 for illegal ops.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, ctl=3, A=0xF0, B=0x20 -> result=0x10, carry=1, zero=0, ovf=0, cflag=1; out_valid exactly 2 cycles after accept.
- Next op ctl=4, A=0x01, B=0x01 (cflag=1 from previous op) -> result=0x03, carry=0, cflag=0. Proves back-to-back use of the carry chain.
- ctl=5, A=0x80, B=0x01 -> result=0x7F, carry=1, ovf=1, neg=0. Then ctl=6, A=0x00, B=0x00 with cflag forced to 0 by cf_wr -> result=0xFF, carry=0, neg=1.
- Hold out_ready=0 with 3 ops issued -> in_ready drops after 2 accepted, and the held result stays stable. Then raise out_ready -> results come out in order with none lost.
- ctl=0xE -> err=1, result=0x00, cflag unchanged. Same cycle cf_wr=1, cf_wdata=1 -> cflag=1.
- Assert reset while 2 ops are in flight -> out_valid=0 and all flags/cflag=0 immediately; no stale result after release.
